// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, mispredict
// redirects, data-memory waits with timeout halt, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_EX,
    input  logic [4:0]       rd_EX,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic             mispredict_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             flush_WB,
    output logic             redirect_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HALT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic       memwait;
    logic       loaduse;
    logic       full_stall;
    logic       run_eval;

    always_comb begin
        memwait = dmem_req_MEM & ~dmem_ready;
        loaduse = MemRead_EX & (rd_EX != 5'd0) &
                  ((uses_rs1_ID & (rs1_ID == rd_EX)) |
                   (uses_rs2_ID & (rs2_ID == rd_EX)));
    end

    always_comb begin
        state_nxt      = state;
        wcnt_nxt       = wcnt;
        full_stall     = 1'b0;
        run_eval       = 1'b0;
        stall_IF       = 1'b0;
        stall_ID       = 1'b0;
        stall_EX       = 1'b0;
        stall_MEM      = 1'b0;
        flush_ID       = 1'b0;
        flush_EX       = 1'b0;
        flush_WB       = 1'b0;
        redirect_valid = 1'b0;

        case (state)
            RUN: begin
                if (memwait) begin
                    full_stall = 1'b1;
                    state_nxt  = MEM_WAIT;
                    wcnt_nxt   = 8'd1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Release cycle: EX is no longer held, so its hazards apply now.
                if (dmem_ready) begin
                    run_eval  = 1'b1;
                    state_nxt = RUN;
                    wcnt_nxt  = 8'd0;
                end else if (wcnt == WAIT_LAST) begin
                    full_stall = 1'b1;
                    state_nxt  = HALT;
                end else begin
                    full_stall = 1'b1;
                    wcnt_nxt   = wcnt + 8'd1;
                end
            end
            HALT:    full_stall = 1'b1;
            default: state_nxt = RUN;
        endcase

        if (full_stall) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_EX  = 1'b1;
            stall_MEM = 1'b1;
            flush_WB  = 1'b1;
        end else if (run_eval) begin
            if (mispredict_EX) begin
                redirect_valid = 1'b1;
                flush_ID       = 1'b1;
                flush_EX       = 1'b1;
            end else if (loaduse) begin
                stall_IF = 1'b1;
                stall_ID = 1'b1;
                flush_EX = 1'b1;
            end
        end

        if (rst) begin
            stall_IF       = 1'b0;
            stall_ID       = 1'b0;
            stall_EX       = 1'b0;
            stall_MEM      = 1'b0;
            flush_ID       = 1'b0;
            flush_EX       = 1'b0;
            flush_WB       = 1'b0;
            redirect_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (stall_IF && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_valid && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (state_nxt == HALT)
                halted <= 1'b1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, branch-mispredict redirects and multi-cycle data-memory waits, including a timeout halt. It also keeps performance counters for stall cycles and applied flushes.

Parameters:
MEM_TIMEOUT, 16, maximum wait cycles for dmem_ready before halting (legal range 2..255).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
MemRead_EX  in  1  instruction in EX is a load
rd_EX  in  5  destination register of the EX instruction
rs1_ID  in  5  rs1 index of the ID instruction
rs2_ID  in  5  rs2 index of the ID instruction
uses_rs1_ID  in  1  ID instruction reads rs1
uses_rs2_ID  in  1  ID instruction reads rs2
mispredict_EX  in  1  branch resolved in EX disagrees with prediction
dmem_req_MEM  in  1  MemRead_MEM or MemWrite_MEM
dmem_ready  in  1  data memory completes this cycle
stall_IF  out  1  hold PC
stall_ID  out  1  hold IF/ID
stall_EX  out  1  hold ID/EX
stall_MEM  out  1  hold EX/MEM
flush_ID  out  1  load bubble into IF/ID
flush_EX  out  1  load bubble into ID/EX
flush_WB  out  1  load bubble into MEM/WB
redirect_valid  out  1  PC takes the corrected target this cycle
halted  out  1  sticky memory-timeout halt
stall_cnt  out  CNT_W  cycles with stall_IF high, saturating
flush_cnt  out  CNT_W  applied mispredict redirects, saturating

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- FSM states: RUN, MEM_WAIT, HALT. A wait counter wcnt is 8 bits wide.
- Reset: state=RUN, wcnt=0, both counters=0, halted=0. While rst is high, every combinational output is 0.
- The control outputs (stall_*, flush_*, redirect_valid) are combinational from state and inputs, so the hold/bubble takes effect in the same cycle. The counters and halted are registered.
- Definitions:
  - memwait = dmem_req_MEM & ~dmem_ready.
  - loaduse = MemRead_EX & (rd_EX != 0) & ((uses_rs1_ID & rs1_ID == rd_EX) | (uses_rs2_ID & rs2_ID == rd_EX)).
- RUN, priority memwait > mispredict > loaduse:
  - memwait: stall_IF/ID/EX/MEM=1, flush_WB=1. Mispredict and loaduse are ignored because EX is held and re-evaluates later. Next state is MEM_WAIT with wcnt=1.
  - mispredict_EX: redirect_valid=1, flush_ID=1, flush_EX=1, no stalls. flush_cnt increments.
  - loaduse: stall_IF=1, stall_ID=1, flush_EX=1. Exactly one bubble per hazard, because the load has advanced by the next cycle.
  - Otherwise all outputs are 0.
- MEM_WAIT:
  - If dmem_ready=1: release that cycle. Outputs are evaluated with RUN rules, with memwait forced to 0. Next state is RUN and wcnt=0.
  - Otherwise, if wcnt == MEM_TIMEOUT-1: full stall. Next state is HALT and halted is set to 1.
  - Otherwise: full stall (stall_IF/ID/EX/MEM=1, flush_WB=1) and wcnt increments.
- HALT: full stall every cycle and halted=1. Only rst exits this state. dmem_ready is ignored.
- stall_cnt increments in every cycle where stall_IF=1 (including MEM_WAIT and HALT cycles). Both counters saturate at all-ones.
- rst asserted in any state, including mid-wait, returns to reset values on the next edge.
- rd_EX=0 never causes a load-use stall.

Test Plan:
- Load-use: MemRead_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 for one cycle -> stall_IF=stall_ID=flush_EX=1 for exactly 1 cycle, stall_cnt=1. Repeating with rd_EX=0 or uses_rs1_ID=0 -> no stall.
- Mispredict concurrent with load-use -> redirect_valid=flush_ID=flush_EX=1, stall_IF=0, flush_cnt=1.
- Memory wait: dmem_req_MEM=1, dmem_ready low for 3 cycles, then high -> full stall plus flush_WB for 3 cycles, all outputs 0 in the 4th cycle, state back to RUN, stall_cnt=3.
- Mispredict during a memory wait held 2 cycles -> no redirect while stalled; redirect_valid=1 in the release cycle; flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> halted=1 after 4 stalled cycles and stays 1 after dmem_ready rises. rst clears halted, the counters and the state.
- rst asserted during the 2nd MEM_WAIT cycle -> next cycle all outputs 0 and wcnt=0; a fresh wait again needs the full MEM_TIMEOUT cycles to halt.
